// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: pulls instructions over an imem req/ack handshake,
// strobes them into the datapath and runs the dmem handshake for LOAD/STORE.
module instr_sequencer #(
  parameter int         ADDR_W  = 8,
  parameter int         TIMEOUT = 15,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  // state  | meaning
  // IDLE   | waiting for start, pc = 0
  // FETCH  | imem_req asserted at pc, waiting for imem_ack
  // EXEC   | one-cycle execute strobe of instr_reg
  // MEM    | dmem_req asserted for LOAD/STORE, waiting for dmem_ack
  // HALT   | HALT_OP executed, parked until rst
  // ERR    | handshake timed out, parked until rst
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;

  // A zero TIMEOUT still needs a one-bit counter to keep the ports legal.
  localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [2:0]       state;
  logic [15:0]      instr_reg;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       opcode;
  logic             is_mem_op;
  logic             is_halt;
  logic             at_limit;

  assign opcode    = instr_reg[15:12];
  assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign is_halt   = (opcode == HALT_OP) && !is_mem_op;
  assign at_limit  = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      instr_reg <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr_reg <= imem_rdata;
            state     <= S_EXEC;
          end else if (at_limit) begin
            state <= S_ERR;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (is_mem_op) begin
            state <= S_MEM;
          end else if (is_halt) begin
            state <= S_HALT;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            pc       <= pc + 1'b1;
            wait_cnt <= '0;
            state    <= S_FETCH;
          end else if (at_limit) begin
            state <= S_ERR;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only the state register and instr_reg, so no ack reaches a req.
  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_EXEC) && !is_halt;
  assign dmem_req    = (state == S_MEM);
  assign dmem_we     = dmem_req && (opcode == OP_STORE);
  assign instr       = (instr_valid || dmem_req) ? instr_reg : 16'h0000;
  assign busy        = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
  assign halted      = (state == S_HALT);
  assign err         = (state == S_ERR);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a program-walking reference model
// queues expected events, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_instr_sequencer;

  localparam int AW     = 4;
  localparam int TO     = 15;
  localparam int NWORDS = 1 << AW;

  typedef enum int {EV_FETCH, EV_EXEC, EV_MEM, EV_HALT, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] data;
    int          pc;
    int          len;
    int          t;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_rdata;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          dmem_req;
  logic          dmem_we;
  logic          dmem_ack;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          err;

  instr_sequencer #(.ADDR_W(AW), .TIMEOUT(TO), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [NWORDS];
  ev_t exp_q[$];
  int  flat_q[$];
  int  mlat_q[$];
  int  pf_q[$];
  int  pm_q[$];
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string nm, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic void push_ev(ev_kind_t k, logic [15:0] d, int p, int l, int t);
    ev_t e;
    e.kind = k; e.data = d; e.pc = p; e.len = l; e.t = t;
    exp_q.push_back(e);
  endfunction

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 2);
    if (r < 9) return $urandom_range(3, 6);
    return TO - 1;
  endfunction

  // Reference model: walk the program from address 0, deciding each handshake
  // latency up front; latency >= TO means the ack never arrives.
  // Times are cycles after the cycle in which start is sampled.
  task automatic build_model(input int stop_step);
    int p, t, lat, mlat;
    logic [15:0] w;
    logic [3:0]  op;
    p = 0;
    t = 1;
    for (int step = 0; step < 1000; step++) begin
      if (pf_q.size() > 0)                        lat = pf_q.pop_front();
      else if (step >= stop_step || step >= 200)  lat = TO + 5;
      else                                        lat = rand_lat();
      flat_q.push_back(lat);
      if (lat >= TO) begin
        push_ev(EV_FETCH, 16'h0, p, TO, t);
        push_ev(EV_ERR, 16'h0, p, 0, t + TO);
        return;
      end
      push_ev(EV_FETCH, 16'h0, p, lat + 1, t);
      t = t + lat + 1;
      w  = mem[p];
      op = w[15:12];
      if (op == 4'hF) begin
        push_ev(EV_HALT, 16'h0, p, 0, t + 1);
        return;
      end
      push_ev(EV_EXEC, w, p, 0, t);
      t = t + 1;
      if (op == 4'h7 || op == 4'h8) begin
        mlat = (pm_q.size() > 0) ? pm_q.pop_front() : rand_lat();
        mlat_q.push_back(mlat);
        if (mlat >= TO) begin
          push_ev(EV_MEM, {15'h0, op == 4'h8}, p, TO, t);
          push_ev(EV_ERR, 16'h0, p, 0, t + TO);
          return;
        end
        push_ev(EV_MEM, {15'h0, op == 4'h8}, p, mlat + 1, t);
        t = t + mlat + 1;
      end
      p = (p + 1) % NWORDS;
    end
  endtask

  // Memory responders: ack on the lat-th cycle (0-based) of each request.
  bit i_act, d_act;
  int i_cnt, i_lat, d_cnt, d_lat;
  always @(negedge clk) begin
    if (!imem_req) begin
      i_act = 1'b0;
      imem_ack = 1'b0;
    end else begin
      if (!i_act) begin
        i_act = 1'b1;
        i_cnt = 0;
        i_lat = (flat_q.size() > 0) ? flat_q.pop_front() : 1000;
      end
      imem_ack   = (i_cnt == i_lat);
      imem_rdata = imem_ack ? mem[imem_addr] : 16'($urandom);
      i_cnt++;
    end
    if (!dmem_req) begin
      d_act = 1'b0;
      dmem_ack = 1'b0;
    end else begin
      if (!d_act) begin
        d_act = 1'b1;
        d_cnt = 0;
        d_lat = (mlat_q.size() > 0) ? mlat_q.pop_front() : 1000;
      end
      dmem_ack = (d_cnt == d_lat);
      d_cnt++;
    end
  end

  task automatic pop_exp(input ev_kind_t k, input string nm, output ev_t e, output bit ok);
    ok = 1'b0;
    e.kind = EV_FETCH; e.data = 16'h0; e.pc = 0; e.len = 0; e.t = 0;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s_order: got an event with an empty scoreboard, expected none", nm);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k) begin
      fails++;
      $display("FAIL %s_order: got event kind %0d expected kind %0d", nm, k, e.kind);
      return;
    end
    ok = 1'b1;
  endtask

  // Monitor
  bit   p_ireq, p_dreq, p_halt, p_err;
  bit   f_open, m_open, ok_x, ok_h;
  int   rel, ilen, dlen;
  ev_t  ev_f, ev_m, ev_x, ev_h;
  logic [15:0] exp_instr;
  always @(negedge clk) begin
    if (start) rel = 0; else rel++;
    if (mon_en) begin
      if (imem_req && !p_ireq) begin
        pop_exp(EV_FETCH, "fetch", ev_f, f_open);
        if (f_open) begin
          check("fetch_addr", imem_addr, ev_f.pc);
          check("fetch_time", rel, ev_f.t);
        end
        ilen = 0;
      end
      if (imem_req) ilen++;
      if (!imem_req && p_ireq && f_open) begin
        check("fetch_len", ilen, ev_f.len);
        f_open = 1'b0;
      end
      if (instr_valid) begin
        pop_exp(EV_EXEC, "exec", ev_x, ok_x);
        if (ok_x) begin
          check("exec_instr", instr, ev_x.data);
          check("exec_pc", pc, ev_x.pc);
          check("exec_time", rel, ev_x.t);
          exp_instr = ev_x.data;
        end
      end
      if (dmem_req && !p_dreq) begin
        pop_exp(EV_MEM, "mem", ev_m, m_open);
        if (m_open) begin
          check("mem_pc", pc, ev_m.pc);
          check("mem_time", rel, ev_m.t);
        end
        dlen = 0;
      end
      if (dmem_req) begin
        dlen++;
        if (m_open) begin
          check("mem_we", dmem_we, ev_m.data[0]);
          check("mem_instr", instr, exp_instr);
        end
      end
      if (!dmem_req && p_dreq && m_open) begin
        check("mem_len", dlen, ev_m.len);
        m_open = 1'b0;
      end
      if (halted && !p_halt) begin
        pop_exp(EV_HALT, "halt", ev_h, ok_h);
        if (ok_h) begin
          check("halt_pc", pc, ev_h.pc);
          check("halt_time", rel, ev_h.t);
        end
      end
      if (err && !p_err) begin
        pop_exp(EV_ERR, "err", ev_h, ok_h);
        if (ok_h) begin
          check("err_pc", pc, ev_h.pc);
          check("err_time", rel, ev_h.t);
        end
      end
      if (!instr_valid && !dmem_req) check("instr_idle", instr, 0);
      if (imem_req || dmem_req || instr_valid) check("busy_active", busy, 1);
      if (halted || err) check("busy_parked", busy, 0);
    end
    p_ireq = imem_req;
    p_dreq = dmem_req;
    p_halt = halted;
    p_err  = err;
  end

  task automatic reset_flush();
    mon_en = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete(); flat_q.delete(); mlat_q.delete();
    f_open = 1'b0; m_open = 1'b0;
  endtask

  task automatic run_scn(input int stop_step);
    int budget;
    reset_flush();
    build_model(stop_step);
    pf_q.delete(); pm_q.delete();
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    budget = 0;
    while (!halted && !err && budget < 5000) begin
      @(posedge clk); #1;
      budget++;
    end
    check("run_completes", halted || err, 1);
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic fill_alu();
    for (int i = 0; i < NWORDS; i++) mem[i] = {4'($urandom_range(0, 6)), 12'($urandom)};
  endtask

  initial begin
    int budget;
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'h0;
    fill_alu();
    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);

    // ADD with same-cycle ack, then a fetch that times out at pc=1
    fill_alu(); mem[0] = 16'h1298;
    pf_q.push_back(0); pf_q.push_back(TO);
    run_scn(1000);

    // LOAD (ack on 3rd cycle), STORE (immediate), HALT
    fill_alu(); mem[0] = 16'h7000; mem[1] = 16'h8000; mem[2] = 16'hF000;
    pf_q.push_back(0); pf_q.push_back(0); pf_q.push_back(0);
    pm_q.push_back(2); pm_q.push_back(0);
    run_scn(1000);
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      @(posedge clk); #1;
      check("halt_hold", halted, 1);
      check("halt_pc_hold", pc, 2);
      check("halt_no_req", imem_req, 0);
      check("halt_no_valid", instr_valid, 0);
    end
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_clears_halted", halted, 0);
    check("rst_clears_pc", pc, 0);
    rst = 1'b0;

    // Acks on the last permitted cycle are accepted
    fill_alu();
    pf_q.push_back(TO - 1); pf_q.push_back(TO - 1); pf_q.push_back(0); pf_q.push_back(TO);
    run_scn(1000);

    // dmem timeout, and dmem ack on the last permitted cycle
    fill_alu(); mem[0] = 16'h7123;
    pf_q.push_back(0); pm_q.push_back(TO);
    run_scn(1000);
    fill_alu(); mem[0] = 16'h8456;
    pf_q.push_back(0); pm_q.push_back(TO - 1); pf_q.push_back(0); pf_q.push_back(TO);
    run_scn(1000);

    // pc wraps: 17 fetches, then a timeout at address 1
    fill_alu();
    for (int i = 0; i < NWORDS + 1; i++) pf_q.push_back(0);
    pf_q.push_back(TO);
    run_scn(1000);

    // Reset while in MEM abandons the transfer
    reset_flush();
    mem[0] = 16'h7abc;
    flat_q.push_back(0); mlat_q.push_back(1000);
    rst = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    budget = 0;
    while (!dmem_req && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check("mem_reached", dmem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_dmem_req", dmem_req, 0);
    check("midrst_pc", pc, 0);
    check("midrst_busy", busy, 0);
    check("midrst_instr", instr, 0);
    rst = 1'b0;

    // Random programs
    for (int s = 0; s < 25; s++) begin
      for (int i = 0; i < NWORDS; i++) begin
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 9);
        if (r < 2)      op = 4'h7;
        else if (r < 4) op = 4'h8;
        else            op = 4'($urandom_range(0, 14));
        mem[i] = {op, 12'($urandom)};
      end
      if ($urandom_range(0, 1) == 1) mem[$urandom_range(0, NWORDS - 1)] = {4'hF, 12'($urandom)};
      run_scn($urandom_range(3, 40));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected the bench to finish");
    $fatal(1);
  end

endmodule
